// File: rtl/id_ex_stage.sv
// ID/EX pipeline register that feeds the ALU its operands and control.
// Define IDEX_FORWARD_EN to add forwarding, WB hold-snooping and load-use stall.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_rt_data
);

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_num1;
  logic [DATA_W-1:0] r_num2;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_write;
  logic              r_mem_read;
  logic [DATA_W-1:0] r_rt_data;

  logic              w_adv;
  logic              w_luh;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_num2;

  assign w_adv = !r_ex_valid | ex_ready;

`ifdef IDEX_FORWARD_EN
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic              r_use_imm;

  logic w_rs_zero;
  logic w_rs_exm;
  logic w_rs_wb;
  logic w_rt_zero;
  logic w_rt_exm;
  logic w_rt_wb;
  logic w_snp_rs;
  logic w_snp_rt;

  assign w_luh = r_ex_valid & r_mem_read
               & (r_rd_addr != '0)
               & ((id_rs_addr == r_rd_addr)
               | (!id_use_imm & (id_rt_addr == r_rd_addr)));

  assign w_rs_zero = (id_rs_addr == '0);
  assign w_rs_exm  = !w_rs_zero & exm_reg_write
                   & (exm_rd_addr == id_rs_addr);
  assign w_rs_wb   = !w_rs_zero & !w_rs_exm & wb_reg_write
                   & (wb_rd_addr == id_rs_addr);

  assign w_rt_zero = (id_rt_addr == '0);
  assign w_rt_exm  = !w_rt_zero & exm_reg_write
                   & (exm_rd_addr == id_rt_addr);
  assign w_rt_wb   = !w_rt_zero & !w_rt_exm & wb_reg_write
                   & (wb_rd_addr == id_rt_addr);

  always_comb begin
    w_rs_val = id_rs_data;
    unique case (1'b1)
      w_rs_zero: w_rs_val = '0;
      w_rs_exm:  w_rs_val = exm_result;
      w_rs_wb:   w_rs_val = wb_data;
      default:   w_rs_val = id_rs_data;
    endcase
  end

  always_comb begin
    w_rt_val = id_rt_data;
    unique case (1'b1)
      w_rt_zero: w_rt_val = '0;
      w_rt_exm:  w_rt_val = exm_result;
      w_rt_wb:   w_rt_val = wb_data;
      default:   w_rt_val = id_rt_data;
    endcase
  end

  // WB may retire a producer while this stage is stalled downstream
  assign w_snp_rs = wb_reg_write & (wb_rd_addr != '0)
                  & (wb_rd_addr == r_rs_addr);
  assign w_snp_rt = wb_reg_write & (wb_rd_addr != '0)
                  & (wb_rd_addr == r_rt_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_use_imm <= 1'b0;
    end else if (!flush && w_adv && !w_luh && in_valid) begin
      r_rs_addr <= id_rs_addr;
      r_rt_addr <= id_rt_addr;
      r_use_imm <= id_use_imm;
    end
  end
`else
  logic w_unused;

  assign w_luh    = 1'b0;
  assign w_rs_val = id_rs_data;
  assign w_rt_val = id_rt_data;
  assign w_unused = ^{id_rs_addr, id_rt_addr,
                      exm_reg_write, exm_rd_addr, exm_result,
                      wb_reg_write, wb_rd_addr, wb_data};
`endif

  assign w_num2   = id_use_imm ? id_imm : w_rt_val;
  assign in_ready = w_adv & !w_luh & !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_num1      <= '0;
      r_num2      <= '0;
      r_alu_ctrl  <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rt_data   <= '0;
    end else if (flush) begin
      r_ex_valid  <= 1'b0;
    end else if (w_adv && w_luh) begin
      r_ex_valid  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (w_adv && in_valid) begin
      r_ex_valid  <= 1'b1;
      r_num1      <= w_rs_val;
      r_num2      <= w_num2;
      r_alu_ctrl  <= id_alu_ctrl;
      r_rd_addr   <= id_rd_addr;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_rt_data   <= w_rt_val;
    end else if (w_adv) begin
      r_ex_valid  <= 1'b0;
    end else begin
`ifdef IDEX_FORWARD_EN
      if (w_snp_rs) r_num1 <= wb_data;
      if (w_snp_rt) r_rt_data <= wb_data;
      if (w_snp_rt && !r_use_imm) r_num2 <= wb_data;
`endif
    end
  end

  assign ex_valid     = r_ex_valid;
  assign num1         = r_num1;
  assign num2         = r_num2;
  assign alu_ctrl     = r_alu_ctrl;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_rt_data   = r_rt_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow IDEX_FORWARD_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [4:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] num1, num2, ex_rt_data;
  logic [4:0]  alu_ctrl, ex_rd_addr;
  logic        ex_reg_write, ex_mem_read;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
    .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .num1(num1), .num2(num2), .alu_ctrl(alu_ctrl),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rt_data(ex_rt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd, ctrl;
    logic        ui, rw, mr;
    logic [31:0] n1, n2, rtd;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_src(input logic [4:0] a,
                                        input logic [31:0] rf);
`ifdef IDEX_FORWARD_EN
    if (a == 5'd0) return 32'd0;
    if (exm_reg_write && exm_rd_addr == a) return exm_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_data;
`endif
    return rf;
  endfunction

  function automatic logic m_luh();
`ifdef IDEX_FORWARD_EN
    exp_t e;
    if (q.size() == 0) return 1'b0;
    e = q[0];
    return e.mr && e.rd != 5'd0 &&
      (id_rs_addr == e.rd || (!id_use_imm && id_rt_addr == e.rd));
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rdy;
      exp_t e;
      exp_rdy = (q.size() == 0 || ex_ready) && !m_luh() && !flush;
      chk("in_ready", in_ready, exp_rdy);
      chk("ex_valid", ex_valid, q.size() != 0);
      if (q.size() != 0 && ex_valid) begin
        e = q[0];
        chk("num1", num1, e.n1);
        chk("num2", num2, e.n2);
        chk("alu_ctrl", alu_ctrl, e.ctrl);
        chk("rt_data", ex_rt_data, e.rtd);
        chk("rd_addr", ex_rd_addr, e.rd);
        chk("reg_write", ex_reg_write, e.rw);
        chk("mem_read", ex_mem_read, e.mr);
      end
      if (flush) q.delete();
      else if (q.size() != 0 && ex_ready) void'(q.pop_front());
      else if (q.size() != 0) begin
`ifdef IDEX_FORWARD_EN
        if (wb_reg_write && wb_rd_addr != 5'd0) begin
          if (wb_rd_addr == q[0].rs) q[0].n1 = wb_data;
          if (wb_rd_addr == q[0].rt) begin
            q[0].rtd = wb_data;
            if (!q[0].ui) q[0].n2 = wb_data;
          end
        end
`endif
      end
      if (in_valid && exp_rdy) begin
        e.rs   = id_rs_addr;
        e.rt   = id_rt_addr;
        e.rd   = id_rd_addr;
        e.ctrl = id_alu_ctrl;
        e.ui   = id_use_imm;
        e.rw   = id_reg_write;
        e.mr   = id_mem_read;
        e.n1   = m_src(id_rs_addr, id_rs_data);
        e.rtd  = m_src(id_rt_addr, id_rt_data);
        e.n2   = id_use_imm ? id_imm : e.rtd;
        q.push_back(e);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic ui, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [4:0] ctrl,
                       input logic rw, input logic mr);
    in_valid     = 1'b1;
    id_rs_addr   = rs;
    id_rs_data   = rsd;
    id_rt_addr   = rt;
    id_rt_data   = rtd;
    id_use_imm   = ui;
    id_imm       = imm;
    id_rd_addr   = rd;
    id_alu_ctrl  = ctrl;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic fwd(input logic xw, input logic [4:0] xa,
                     input logic [31:0] xd, input logic ww,
                     input logic [4:0] wa, input logic [31:0] wd);
    exm_reg_write = xw;
    exm_rd_addr   = xa;
    exm_result    = xd;
    wb_reg_write  = ww;
    wb_rd_addr    = wa;
    wb_data       = wd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 1'b0);
    chk({tag, "_num1"}, num1, 32'd0);
    chk({tag, "_num2"}, num2, 32'd0);
    chk({tag, "_ctrl"}, alu_ctrl, 5'd0);
    chk({tag, "_rtd"}, ex_rt_data, 32'd0);
    chk({tag, "_rd"}, ex_rd_addr, 5'd0);
    chk({tag, "_rw"}, ex_reg_write, 1'b0);
    chk({tag, "_mr"}, ex_mem_read, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    offer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    #12;
    chk_zero("rst");
    rst_n = 1'b1;
    cyc();

    offer(3, 5, 4, 7, 0, 0, 5, 0, 1, 0);
    cyc();
    in_valid = 1'b0;
    cyc();

    offer(8, 32'h11, 0, 32'h33, 0, 0, 6, 1, 1, 0);
    fwd(1, 8, 32'h100, 1, 8, 32'h200);
    cyc();
    offer(0, 32'h44, 8, 32'h22, 0, 0, 7, 2, 1, 0);
    fwd(1, 0, 32'h99, 0, 0, 0);
    cyc();
    offer(6, 32'h1, 6, 32'h2, 1, 32'h1234, 7, 3, 1, 0);
    fwd(0, 0, 0, 1, 6, 32'h66);
    cyc();
    in_valid = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    cyc();

    offer(1, 32'h1000, 0, 0, 1, 4, 9, 0, 1, 1);
    cyc();
    offer(9, 32'hBAD, 0, 0, 0, 0, 10, 1, 1, 0);
    cyc();
    fwd(0, 0, 0, 1, 9, 32'hDEAD);
    cyc();
    in_valid = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    cyc(2);

    offer(1, 32'h10, 2, 32'h20, 0, 0, 3, 2, 1, 0);
    cyc();
    offer(4, 32'h40, 5, 32'h50, 0, 0, 6, 3, 1, 0);
    ex_ready = 1'b0;
    cyc();
    fwd(0, 0, 0, 1, 2, 32'h55);
    cyc();
    fwd(0, 0, 0, 0, 0, 0);
    cyc();
    ex_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(2);

    offer(11, 32'hA1, 12, 32'hA2, 0, 0, 13, 4, 1, 0);
    cyc();
    offer(14, 32'hB1, 15, 32'hB2, 0, 0, 16, 5, 1, 0);
    ex_ready = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    ex_ready = 1'b1;
    cyc(2);

    offer(17, 32'hC1, 18, 32'hC2, 1, 32'hC3, 19, 6, 1, 1);
    cyc();
    in_valid = 1'b0;
    ex_ready = 1'b0;
    cyc();
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_zero("arst");
    #3;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    cyc();
    offer(20, 32'hD1, 21, 32'hD2, 0, 0, 22, 7, 1, 0);
    cyc();
    in_valid = 1'b0;
    cyc(3);

    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
